// File: rtl/set_assoc_cache_ctrl.sv
// Set-associative cache controller: tag/valid storage, tree-PLRU replacement,
// write-through / no-write-allocate policy with a read-miss refill sequence.
//
// Optional build macro: CACHE_PERF_CNT_EN adds saturating hit/miss counters.
//
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   flush              invalidate all lines (deferred until idle if busy)
//   rd, wr, index, tag processor request (rd&wr is treated as a write)
//   ready              memory completion for WR_MEM / RD_MEM
//   loctn              data-array line address {set, way}
//   refill, update     data-array fill / write strobes
//   read_from_mem      memory read request
//   write_to_mem       memory write request
//   stall              processor stall
//   hit, miss          one-cycle lookup result pulses
//   hit_count, miss_count  (CACHE_PERF_CNT_EN only) saturating counters
module set_assoc_cache_ctrl #(
  parameter int unsigned INDEX_BITS = 2,
  parameter int unsigned WAY_BITS   = 2,
  parameter int unsigned TAG_BITS   = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         rd,
  input  logic                         wr,
  input  logic [INDEX_BITS-1:0]        index,
  input  logic [TAG_BITS-1:0]          tag,
  input  logic                         ready,
  output logic [INDEX_BITS+WAY_BITS-1:0] loctn,
  output logic                         refill,
  output logic                         update,
  output logic                         read_from_mem,
  output logic                         write_to_mem,
  output logic                         stall,
  output logic                         hit,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
`endif
  output logic                         miss
);

  localparam int unsigned SETS     = 2**INDEX_BITS;
  localparam int unsigned WAYS     = 2**WAY_BITS;
  localparam int unsigned LOC_BITS = INDEX_BITS + WAY_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, WR_MEM, RD_MEM, REFILL, DONE} state_t;

  state_t                                      state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]                   valid_q, valid_d;
  logic [SETS-1:0][WAYS-2:0]                   plru_q, plru_d;
  logic [SETS-1:0][WAYS-1:0][TAG_BITS-1:0]     tag_q;
  logic [INDEX_BITS-1:0]                       req_idx_q, req_idx_d;
  logic [TAG_BITS-1:0]                         req_tag_q, req_tag_d;
  logic                                        req_wr_q, req_wr_d;
  logic [WAY_BITS-1:0]                         victim_q, victim_d;
  logic                                        flush_pend_q, flush_pend_d;
  logic                                        tag_we;
  logic                                        flush_apply;

  logic [LOC_BITS-1:0] loctn_d;
  logic refill_d, update_d, read_from_mem_d, write_to_mem_d, stall_d, hit_d, miss_d;

  logic                lk_hit, inv_found;
  logic [WAY_BITS-1:0] lk_way, inv_way, vict_way;

  // Walk the tree from the root: 0 selects the lower half, 1 the upper half.
  function automatic logic [WAY_BITS-1:0] plru_pick(input logic [WAYS-2:0] t);
    logic [WAY_BITS-1:0] w;
    logic                b;
    int                  node;
    w    = '0;
    node = 0;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      b = 1'b0;
      for (int n = 0; n < int'(WAYS) - 1; n++)
        if (n == node) b = t[n];
      w    = WAY_BITS'({w, b});
      node = 2 * node + (b ? 2 : 1);
    end
    return w;
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                 input logic [WAY_BITS-1:0] w);
    logic [WAYS-2:0]     r;
    logic [WAY_BITS-1:0] ws;
    logic                b;
    int                  node;
    r    = t;
    ws   = w;
    node = 0;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      b = ws[WAY_BITS-1];
      for (int n = 0; n < int'(WAYS) - 1; n++)
        if (n == node) r[n] = ~b;
      ws   = ws << 1;
      node = 2 * node + (b ? 2 : 1);
    end
    return r;
  endfunction

  // Parallel tag compare and invalid-way search; lowest way wins in both.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
        lk_hit = 1'b1;
        lk_way = WAY_BITS'(w);
      end
      if (!valid_q[req_idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    vict_way = inv_found ? inv_way : plru_pick(plru_q[req_idx_q]);
  end

  assign flush_apply = (state_q == IDLE) && (flush || flush_pend_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    plru_d          = plru_q;
    req_idx_d       = req_idx_q;
    req_tag_d       = req_tag_q;
    req_wr_d        = req_wr_q;
    victim_d        = victim_q;
    flush_pend_d    = flush_pend_q | flush;
    tag_we          = 1'b0;
    loctn_d         = loctn;
    refill_d        = 1'b0;
    update_d        = 1'b0;
    hit_d           = 1'b0;
    miss_d          = 1'b0;
    read_from_mem_d = read_from_mem;
    write_to_mem_d  = write_to_mem;
    stall_d         = stall;

    unique case (state_q)
      IDLE: begin
        if (flush_apply) begin
          valid_d      = '0;
          plru_d       = '0;
          flush_pend_d = 1'b0;
        end else if (rd || wr) begin
          req_idx_d = index;
          req_tag_d = tag;
          req_wr_d  = wr;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lk_hit) begin
          hit_d              = 1'b1;
          loctn_d            = {req_idx_q, lk_way};
          plru_d[req_idx_q]  = plru_touch(plru_q[req_idx_q], lk_way);
          if (req_wr_q) begin
            update_d       = 1'b1;
            stall_d        = 1'b1;
            write_to_mem_d = 1'b1;
            state_d        = WR_MEM;
          end else begin
            state_d        = DONE;
          end
        end else begin
          miss_d  = 1'b1;
          stall_d = 1'b1;
          if (req_wr_q) begin
            write_to_mem_d  = 1'b1;
            state_d         = WR_MEM;
          end else begin
            victim_d        = vict_way;
            loctn_d         = {req_idx_q, vict_way};
            read_from_mem_d = 1'b1;
            state_d         = RD_MEM;
          end
        end
      end
      WR_MEM: begin
        if (ready) begin
          write_to_mem_d = 1'b0;
          stall_d        = 1'b0;
          state_d        = DONE;
        end
      end
      RD_MEM: begin
        if (ready) begin
          read_from_mem_d = 1'b0;
          refill_d        = 1'b1;
          state_d         = REFILL;
        end
      end
      REFILL: begin
        tag_we                       = 1'b1;
        valid_d[req_idx_q][victim_q] = 1'b1;
        plru_d[req_idx_q]            = plru_touch(plru_q[req_idx_q], victim_q);
        stall_d                      = 1'b0;
        state_d                      = DONE;
      end
      DONE: begin
        if (!rd && !wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      plru_q        <= '0;
      req_idx_q     <= '0;
      req_tag_q     <= '0;
      req_wr_q      <= 1'b0;
      victim_q      <= '0;
      flush_pend_q  <= 1'b0;
      loctn         <= '0;
      refill        <= 1'b0;
      update        <= 1'b0;
      read_from_mem <= 1'b0;
      write_to_mem  <= 1'b0;
      stall         <= 1'b0;
      hit           <= 1'b0;
      miss          <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      plru_q        <= plru_d;
      req_idx_q     <= req_idx_d;
      req_tag_q     <= req_tag_d;
      req_wr_q      <= req_wr_d;
      victim_q      <= victim_d;
      flush_pend_q  <= flush_pend_d;
      loctn         <= loctn_d;
      refill        <= refill_d;
      update        <= update_d;
      read_from_mem <= read_from_mem_d;
      write_to_mem  <= write_to_mem_d;
      stall         <= stall_d;
      hit           <= hit_d;
      miss          <= miss_d;
    end
  end

  // Tag array has no reset; validity is tracked by valid_q.
  always_ff @(posedge clock) begin
    if (tag_we) tag_q[req_idx_q][victim_q] <= req_tag_q;
  end

`ifdef CACHE_PERF_CNT_EN
  // Saturating event counters, cleared whenever a flush takes effect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush_apply) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_d && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (miss_d && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Randomized self-checking bench for set_assoc_cache_ctrl with a
// transaction-level cache model (valid/tag arrays, tree-PLRU bits).
module tb_set_assoc_cache_ctrl;

  localparam int IB = 2;
  localparam int WB = 2;
  localparam int TB = 6;
  localparam int NS = 4;
  localparam int NW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            rd = 1'b0;
  logic            wr = 1'b0;
  logic [IB-1:0]   index = '0;
  logic [TB-1:0]   tag = '0;
  logic            ready = 1'b0;
  logic [IB+WB-1:0] loctn;
  logic            refill, update, read_from_mem, write_to_mem, stall, hit, miss;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]     hit_count, miss_count;
`endif

  set_assoc_cache_ctrl #(.INDEX_BITS(IB), .WAY_BITS(WB), .TAG_BITS(TB)) dut (
    .clock(clock), .reset(reset), .flush(flush), .rd(rd), .wr(wr),
    .index(index), .tag(tag), .ready(ready), .loctn(loctn),
    .refill(refill), .update(update), .read_from_mem(read_from_mem),
    .write_to_mem(write_to_mem), .stall(stall), .hit(hit),
`ifdef CACHE_PERF_CNT_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .miss(miss)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit m_valid [NS][NW];
  int m_tag   [NS][NW];
  bit m_plru  [NS][NW-1];
  int m_loctn;
  int m_hits, m_misses;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_clear(input bit clr_loc);
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
      for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 1'b0;
    end
    if (clr_loc) m_loctn = 0;
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic int model_victim(input int s);
    int node, w, b;
    for (int i = 0; i < NW; i++) if (!m_valid[s][i]) return i;
    node = 0;
    w = 0;
    for (int l = 0; l < WB; l++) begin
      b = int'(m_plru[s][node]);
      w = w * 2 + b;
      node = 2 * node + 1 + b;
    end
    return w;
  endfunction

  function automatic void model_touch(input int s, input int w);
    int node, b;
    node = 0;
    for (int l = 0; l < WB; l++) begin
      b = (w >> (WB - 1 - l)) & 1;
      m_plru[s][node] = (b == 0);
      node = 2 * node + 1 + b;
    end
  endfunction

  task automatic check_counters();
`ifdef CACHE_PERF_CNT_EN
    check("hit_count", hit_count, 32'(m_hits));
    check("miss_count", miss_count, 32'(m_misses));
`endif
  endtask

  // One processor request; dly = idle cycles before ready, fl = flush during memory wait.
  task automatic do_req(input bit is_wr, input int idx, input int t, input int dly,
                        input bit fl, input bit stray_rdy);
    int hw, vic;
    hw = -1;
    for (int w = NW - 1; w >= 0; w--)
      if (m_valid[idx][w] && m_tag[idx][w] == t) hw = w;
    vic = model_victim(idx);

    index = IB'(idx);
    tag   = TB'(t);
    rd    = !is_wr;
    wr    = is_wr;
    if (is_wr && $urandom_range(0, 3) == 0) rd = 1'b1;
    ready = stray_rdy;
    tick();
    rd = 1'b0;
    wr = 1'b0;
    tick();
    ready = 1'b0;

    check("hit", hit, 32'(hw >= 0));
    check("miss", miss, 32'(hw < 0));
    if (hw >= 0) begin
      m_hits++;
      m_loctn = idx * NW + hw;
      model_touch(idx, hw);
    end else begin
      m_misses++;
      if (!is_wr) m_loctn = idx * NW + vic;
    end
    check("loctn", loctn, 32'(m_loctn));
    check("update", update, 32'(is_wr && hw >= 0));
    check("stall", stall, 32'(is_wr || hw < 0));
    check("rd_mem", read_from_mem, 32'(!is_wr && hw < 0));
    check("wr_mem", write_to_mem, 32'(is_wr));

    if (is_wr || hw < 0) begin
      if (fl) flush = 1'b1;
      for (int d = 0; d < dly; d++) begin
        tick();
        check("stall_wait", stall, 32'd1);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      flush = 1'b0;
      check("rd_mem_done", read_from_mem, 32'd0);
      check("wr_mem_done", write_to_mem, 32'd0);
      if (!is_wr) begin
        check("refill", refill, 32'd1);
        check("stall_refill", stall, 32'd1);
        tick();
        check("refill_end", refill, 32'd0);
        check("stall_end", stall, 32'd0);
        m_valid[idx][vic] = 1'b1;
        m_tag[idx][vic] = t;
        model_touch(idx, vic);
      end else begin
        check("stall_end", stall, 32'd0);
      end
    end else begin
      tick();
      check("stall_rdhit", stall, 32'd0);
    end
    tick();
    tick();
    tick();
    if (fl && (is_wr || hw < 0)) model_clear(1'b0);
    check("loctn_hold", loctn, 32'(m_loctn));
    check_counters();
  endtask

  initial begin
    model_clear(1'b1);
    tick();
    tick();
    check("rst_loctn", loctn, 32'd0);
    check("rst_stall", stall, 32'd0);
    check("rst_hit", hit, 32'd0);
    reset = 1'b0;
    tick();

    // Directed: first read misses into way 0 of set 1, then hits.
    do_req(1'b0, 1, 'h2A, 3, 1'b0, 1'b0);
    do_req(1'b0, 1, 'h2A, 0, 1'b0, 1'b0);
    check("rehit_loc", loctn, 32'h4);

    // Flush in IDLE together with rd: request ignored, cache emptied.
    flush = 1'b1;
    rd = 1'b1;
    index = 2'd1;
    tag = 6'h2A;
    tick();
    flush = 1'b0;
    rd = 1'b0;
    tick();
    check("flush_idle_hit", hit, 32'd0);
    check("flush_idle_miss", miss, 32'd0);
    tick();
    model_clear(1'b0);

    // PLRU victim selection.
    for (int i = 1; i <= 4; i++) do_req(1'b0, 1, i, 1, 1'b0, 1'b0);
    do_req(1'b0, 1, 1, 0, 1'b0, 1'b0);
    do_req(1'b0, 1, 5, 2, 1'b0, 1'b0);
    check("plru_victim", loctn, 32'h6);

    // Write hit, write miss (no allocate), then the missed tag still misses.
    do_req(1'b0, 1, 'h2A, 1, 1'b0, 1'b0);
    do_req(1'b1, 1, 'h2A, 2, 1'b0, 1'b0);
    do_req(1'b1, 1, 'h3F, 2, 1'b0, 1'b0);
    do_req(1'b0, 1, 'h3F, 1, 1'b0, 1'b0);

    // Flush during RD_MEM: transaction completes, then the cache is empty.
    do_req(1'b0, 2, 'h11, 2, 1'b1, 1'b0);
    do_req(1'b0, 1, 'h2A, 1, 1'b0, 1'b0);

    // Random traffic with a small tag pool to mix hits and misses.
    for (int k = 0; k < 200; k++)
      do_req(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, NS - 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0));

    // Reset asserted in RD_MEM takes effect without a clock edge.
    index = 2'd3;
    tag = 6'h3E;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    check("pre_rst_stall", stall, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_stall", stall, 32'd0);
    check("mid_rst_rdmem", read_from_mem, 32'd0);
    check("mid_rst_miss", miss, 32'd0);
    check("mid_rst_loctn", loctn, 32'd0);
    model_clear(1'b1);
    check_counters();
    tick();
    reset = 1'b0;
    tick();
    do_req(1'b0, 1, 'h2A, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
